// File: rtl/rice_core_pkg.sv
// Shared types and constants for the rice core: ALU operation encoding,
// RV32I opcode/funct7 values and the decoded bundle passed from ID to EX.
package rice_core_pkg;

  localparam int RICE_CORE_XLEN = 32;

  localparam logic [6:0] RICE_CORE_OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] RICE_CORE_OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] RICE_CORE_OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] RICE_CORE_OPCODE_AUIPC  = 7'b0010111;

  localparam logic [6:0] RICE_CORE_FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] RICE_CORE_FUNCT7_ALT  = 7'b0100000;

  // ADD must stay at encoding 0 so a cleared bundle reads as "ADD 0 + 0"
  typedef enum logic [2:0] {
    RICE_CORE_ALU_ADD = 3'd0,
    RICE_CORE_ALU_SUB = 3'd1,
    RICE_CORE_ALU_SLL = 3'd2,
    RICE_CORE_ALU_SRL = 3'd3,
    RICE_CORE_ALU_SRA = 3'd4,
    RICE_CORE_ALU_XOR = 3'd5,
    RICE_CORE_ALU_OR  = 3'd6,
    RICE_CORE_ALU_AND = 3'd7
  } rice_core_alu_command;

  // NONE must stay at encoding 0 so a cleared bundle selects operand 0
  typedef enum logic [1:0] {
    RICE_CORE_ALU_SOURCE_NONE = 2'd0,
    RICE_CORE_ALU_SOURCE_RS   = 2'd1,
    RICE_CORE_ALU_SOURCE_IMM  = 2'd2,
    RICE_CORE_ALU_SOURCE_PC   = 2'd3
  } rice_core_alu_source;

  typedef struct packed {
    rice_core_alu_command command;
    rice_core_alu_source  source_1;
    rice_core_alu_source  source_2;
  } rice_core_alu_operation;

  typedef struct packed {
    logic [RICE_CORE_XLEN-1:0] pc;
    rice_core_alu_operation    alu_operation;
    logic [RICE_CORE_XLEN-1:0] imm;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [4:0]                rd;
    logic                      rd_write;
    logic                      illegal;
  } rice_core_id_bundle;

endpackage

// File: rtl/rice_core_decoder.sv
// Purely combinational RV32I ALU-subset decoder: instruction word and PC in,
// decoded ID bundle out. Unsupported words become a non-writing ADD 0 + 0.
module rice_core_decoder
  import rice_core_pkg::*;
(
  input  logic [31:0]               inst_i,
  input  logic [RICE_CORE_XLEN-1:0] pc_i,
  output rice_core_id_bundle        bundle_o
);

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [RICE_CORE_XLEN-1:0] immI;
  logic [RICE_CORE_XLEN-1:0] immU;
  logic                      legal;
  rice_core_alu_operation    operation;
  logic [RICE_CORE_XLEN-1:0] imm;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign immI   = {{20{inst_i[31]}}, inst_i[31:20]};
  assign immU   = {inst_i[31:12], 12'b0};

  // Classify the instruction and pick ALU command, operand sources and immediate
  always_comb begin
    legal              = 1'b0;
    operation.command  = RICE_CORE_ALU_ADD;
    operation.source_1 = RICE_CORE_ALU_SOURCE_NONE;
    operation.source_2 = RICE_CORE_ALU_SOURCE_NONE;
    imm                = '0;
    case (opcode)
      RICE_CORE_OPCODE_LUI: begin
        legal              = 1'b1;
        operation.source_2 = RICE_CORE_ALU_SOURCE_IMM;
        imm                = immU;
      end
      RICE_CORE_OPCODE_AUIPC: begin
        legal              = 1'b1;
        operation.source_1 = RICE_CORE_ALU_SOURCE_PC;
        operation.source_2 = RICE_CORE_ALU_SOURCE_IMM;
        imm                = immU;
      end
      RICE_CORE_OPCODE_OP_IMM: begin
        operation.source_1 = RICE_CORE_ALU_SOURCE_RS;
        operation.source_2 = RICE_CORE_ALU_SOURCE_IMM;
        imm                = immI;
        case (funct3)
          3'b000: begin legal = 1'b1; operation.command = RICE_CORE_ALU_ADD; end
          3'b100: begin legal = 1'b1; operation.command = RICE_CORE_ALU_XOR; end
          3'b110: begin legal = 1'b1; operation.command = RICE_CORE_ALU_OR;  end
          3'b111: begin legal = 1'b1; operation.command = RICE_CORE_ALU_AND; end
          3'b001: begin
            if (funct7 == RICE_CORE_FUNCT7_BASE) begin
              legal             = 1'b1;
              operation.command = RICE_CORE_ALU_SLL;
            end
          end
          3'b101: begin
            if (funct7 == RICE_CORE_FUNCT7_BASE) begin
              legal             = 1'b1;
              operation.command = RICE_CORE_ALU_SRL;
            end else if (funct7 == RICE_CORE_FUNCT7_ALT) begin
              legal             = 1'b1;
              operation.command = RICE_CORE_ALU_SRA;
            end
          end
          default: ;
        endcase
      end
      RICE_CORE_OPCODE_OP: begin
        operation.source_1 = RICE_CORE_ALU_SOURCE_RS;
        operation.source_2 = RICE_CORE_ALU_SOURCE_RS;
        case ({funct7, funct3})
          {RICE_CORE_FUNCT7_BASE, 3'b000}: begin legal = 1'b1; operation.command = RICE_CORE_ALU_ADD; end
          {RICE_CORE_FUNCT7_BASE, 3'b001}: begin legal = 1'b1; operation.command = RICE_CORE_ALU_SLL; end
          {RICE_CORE_FUNCT7_BASE, 3'b100}: begin legal = 1'b1; operation.command = RICE_CORE_ALU_XOR; end
          {RICE_CORE_FUNCT7_BASE, 3'b101}: begin legal = 1'b1; operation.command = RICE_CORE_ALU_SRL; end
          {RICE_CORE_FUNCT7_BASE, 3'b110}: begin legal = 1'b1; operation.command = RICE_CORE_ALU_OR;  end
          {RICE_CORE_FUNCT7_BASE, 3'b111}: begin legal = 1'b1; operation.command = RICE_CORE_ALU_AND; end
          {RICE_CORE_FUNCT7_ALT,  3'b000}: begin legal = 1'b1; operation.command = RICE_CORE_ALU_SUB; end
          {RICE_CORE_FUNCT7_ALT,  3'b101}: begin legal = 1'b1; operation.command = RICE_CORE_ALU_SRA; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Assemble the bundle; an illegal word keeps the zeroed ADD/NONE/NONE/imm 0 operation
  always_comb begin
    bundle_o          = '0;
    bundle_o.pc       = pc_i;
    bundle_o.rd       = inst_i[11:7];
    bundle_o.rs1      = ((opcode == RICE_CORE_OPCODE_LUI) || (opcode == RICE_CORE_OPCODE_AUIPC))
                        ? 5'd0 : inst_i[19:15];
    bundle_o.rs2      = (opcode == RICE_CORE_OPCODE_OP) ? inst_i[24:20] : 5'd0;
    bundle_o.illegal  = !legal;
    bundle_o.rd_write = legal && (inst_i[11:7] != 5'd0);
    if (legal) begin
      bundle_o.alu_operation = operation;
      bundle_o.imm           = imm;
    end
  end

endmodule

// File: rtl/rice_core_id_stage.sv
// Instruction-decode stage: decodes fetched words and hands them to execute
// through a main register backed by a skid register, so the fetch-side ready
// comes straight from a flop and no bundle is lost under backpressure.
module rice_core_id_stage
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
)
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_if_valid,
  output logic                   o_if_ready,
  input  logic [XLEN-1:0]        i_if_pc,
  input  logic [31:0]            i_if_inst,
  output logic                   o_ex_valid,
  input  logic                   i_ex_ready,
  output logic [XLEN-1:0]        o_ex_pc,
  output rice_core_alu_operation o_ex_alu_operation,
  output logic [XLEN-1:0]        o_ex_imm_value,
  output logic [4:0]             o_ex_rs1,
  output logic [4:0]             o_ex_rs2,
  output logic [4:0]             o_ex_rd,
  output logic                   o_ex_rd_write,
  output logic                   o_ex_illegal
);

  rice_core_id_bundle decoded;
  rice_core_id_bundle mainBundle_q, mainBundle_d;
  rice_core_id_bundle skidBundle_q, skidBundle_d;
  logic               mainValid_q, mainValid_d;
  logic               skidValid_q, skidValid_d;
  logic               ifReady_q, ifReady_d;
  logic               accept;
  logic               consume;

  rice_core_decoder u_decoder (
    .inst_i   (i_if_inst),
    .pc_i     (i_if_pc),
    .bundle_o (decoded)
  );

  assign accept  = i_if_valid && ifReady_q;
  assign consume = mainValid_q && i_ex_ready;

  // Buffer steering: skid drains into main first so program order is kept
  always_comb begin
    mainValid_d  = mainValid_q;
    mainBundle_d = mainBundle_q;
    skidValid_d  = skidValid_q;
    skidBundle_d = skidBundle_q;
    if (i_flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (consume || !mainValid_q) begin
      if (skidValid_q) begin
        mainValid_d  = 1'b1;
        mainBundle_d = skidBundle_q;
        skidValid_d  = accept;
        if (accept) begin
          skidBundle_d = decoded;
        end
      end else if (accept) begin
        mainValid_d  = 1'b1;
        mainBundle_d = decoded;
      end else begin
        mainValid_d  = 1'b0;
      end
    end else if (accept) begin
      skidValid_d  = 1'b1;
      skidBundle_d = decoded;
    end
    ifReady_d = !skidValid_d;
  end

  // State registers with synchronous reset clearing every entry and payload
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mainValid_q  <= 1'b0;
      mainBundle_q <= '0;
      skidValid_q  <= 1'b0;
      skidBundle_q <= '0;
      ifReady_q    <= 1'b1;
    end else begin
      mainValid_q  <= mainValid_d;
      mainBundle_q <= mainBundle_d;
      skidValid_q  <= skidValid_d;
      skidBundle_q <= skidBundle_d;
      ifReady_q    <= ifReady_d;
    end
  end

  assign o_if_ready         = ifReady_q;
  assign o_ex_valid         = mainValid_q;
  assign o_ex_pc            = mainBundle_q.pc;
  assign o_ex_alu_operation = mainBundle_q.alu_operation;
  assign o_ex_imm_value     = mainBundle_q.imm;
  assign o_ex_rs1           = mainBundle_q.rs1;
  assign o_ex_rs2           = mainBundle_q.rs2;
  assign o_ex_rd            = mainBundle_q.rd;
  assign o_ex_rd_write      = mainBundle_q.rd_write;
  assign o_ex_illegal       = mainBundle_q.illegal;

endmodule

// File: tb/tb_rice_core_id_stage.sv
// Self-checking bench for the ID stage: a scoreboard queue holds the model's
// expected bundle for every accepted instruction and is compared whenever
// execute consumes a bundle; scenario tasks add targeted inline checks.
module tb_rice_core_id_stage;
  import rice_core_pkg::*;

  logic                   i_clk;
  logic                   i_rst;
  logic                   i_flush;
  logic                   i_if_valid;
  logic                   o_if_ready;
  logic [31:0]            i_if_pc;
  logic [31:0]            i_if_inst;
  logic                   o_ex_valid;
  logic                   i_ex_ready;
  logic [31:0]            o_ex_pc;
  rice_core_alu_operation o_ex_alu_operation;
  logic [31:0]            o_ex_imm_value;
  logic [4:0]             o_ex_rs1;
  logic [4:0]             o_ex_rs2;
  logic [4:0]             o_ex_rd;
  logic                   o_ex_rd_write;
  logic                   o_ex_illegal;

  rice_core_id_bundle sbQueue[$];
  int nCompared;
  int nMismatched;

  rice_core_id_stage #(.XLEN(32)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_flush            (i_flush),
    .i_if_valid         (i_if_valid),
    .o_if_ready         (o_if_ready),
    .i_if_pc            (i_if_pc),
    .i_if_inst          (i_if_inst),
    .o_ex_valid         (o_ex_valid),
    .i_ex_ready         (i_ex_ready),
    .o_ex_pc            (o_ex_pc),
    .o_ex_alu_operation (o_ex_alu_operation),
    .o_ex_imm_value     (o_ex_imm_value),
    .o_ex_rs1           (o_ex_rs1),
    .o_ex_rs2           (o_ex_rs2),
    .o_ex_rd            (o_ex_rd),
    .o_ex_rd_write      (o_ex_rd_write),
    .o_ex_illegal       (o_ex_illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 i_clk = ~i_clk;

  // Reference decoder built straight from the RV32I encoding tables
  function automatic rice_core_id_bundle modelDecode(input logic [31:0] inst, input logic [31:0] pc);
    rice_core_id_bundle   e;
    logic [6:0]           opc;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic                 ok;
    rice_core_alu_command cmd;
    rice_core_alu_source  s1;
    rice_core_alu_source  s2;
    logic [31:0]          im;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    ok  = 1'b0;
    cmd = RICE_CORE_ALU_ADD;
    s1  = RICE_CORE_ALU_SOURCE_NONE;
    s2  = RICE_CORE_ALU_SOURCE_NONE;
    im  = 32'h0;
    e   = '0;
    e.pc = pc;
    e.rd = inst[11:7];
    if (opc == 7'h37) begin
      ok = 1'b1; s2 = RICE_CORE_ALU_SOURCE_IMM; im = {inst[31:12], 12'h000};
    end else if (opc == 7'h17) begin
      ok = 1'b1; s1 = RICE_CORE_ALU_SOURCE_PC; s2 = RICE_CORE_ALU_SOURCE_IMM;
      im = {inst[31:12], 12'h000};
    end else if (opc == 7'h13) begin
      e.rs1 = inst[19:15];
      s1 = RICE_CORE_ALU_SOURCE_RS; s2 = RICE_CORE_ALU_SOURCE_IMM;
      im = {{20{inst[31]}}, inst[31:20]};
      ok = 1'b1;
      case (f3)
        3'd0: cmd = RICE_CORE_ALU_ADD;
        3'd4: cmd = RICE_CORE_ALU_XOR;
        3'd6: cmd = RICE_CORE_ALU_OR;
        3'd7: cmd = RICE_CORE_ALU_AND;
        3'd1: begin cmd = RICE_CORE_ALU_SLL; ok = (f7 == 7'h00); end
        3'd5: begin
          cmd = (f7 == 7'h20) ? RICE_CORE_ALU_SRA : RICE_CORE_ALU_SRL;
          ok  = (f7 == 7'h00) || (f7 == 7'h20);
        end
        default: ok = 1'b0;
      endcase
    end else if (opc == 7'h33) begin
      e.rs1 = inst[19:15];
      e.rs2 = inst[24:20];
      s1 = RICE_CORE_ALU_SOURCE_RS; s2 = RICE_CORE_ALU_SOURCE_RS;
      if (f7 == 7'h00) begin
        ok = 1'b1;
        case (f3)
          3'd0: cmd = RICE_CORE_ALU_ADD;
          3'd1: cmd = RICE_CORE_ALU_SLL;
          3'd4: cmd = RICE_CORE_ALU_XOR;
          3'd5: cmd = RICE_CORE_ALU_SRL;
          3'd6: cmd = RICE_CORE_ALU_OR;
          3'd7: cmd = RICE_CORE_ALU_AND;
          default: ok = 1'b0;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        ok = 1'b1; cmd = RICE_CORE_ALU_SUB;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        ok = 1'b1; cmd = RICE_CORE_ALU_SRA;
      end
    end else begin
      e.rs1 = inst[19:15];
    end
    if (ok) begin
      e.alu_operation.command  = cmd;
      e.alu_operation.source_1 = s1;
      e.alu_operation.source_2 = s2;
      e.imm                    = im;
      e.rd_write               = (inst[11:7] != 5'd0);
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // One clock: scoreboard work at the falling edge, then return 1 after the rising edge
  task automatic tick();
    rice_core_id_bundle got;
    rice_core_id_bundle exp;
    @(negedge i_clk);
    if (i_rst || i_flush) begin
      sbQueue.delete();
    end else begin
      if (o_ex_valid && i_ex_ready) begin
        got.pc            = o_ex_pc;
        got.alu_operation = o_ex_alu_operation;
        got.imm           = o_ex_imm_value;
        got.rs1           = o_ex_rs1;
        got.rs2           = o_ex_rs2;
        got.rd            = o_ex_rd;
        got.rd_write      = o_ex_rd_write;
        got.illegal       = o_ex_illegal;
        nCompared++;
        if (sbQueue.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL unexpected_output: got pc=%h op=%h imm=%h, expected no bundle", got.pc, got.alu_operation, got.imm);
        end else begin
          exp = sbQueue.pop_front();
          if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL bundle: got pc=%h op=%h imm=%h rs1=%0d rs2=%0d rd=%0d w=%b ill=%b, expected pc=%h op=%h imm=%h rs1=%0d rs2=%0d rd=%0d w=%b ill=%b",
                     got.pc, got.alu_operation, got.imm, got.rs1, got.rs2, got.rd, got.rd_write, got.illegal,
                     exp.pc, exp.alu_operation, exp.imm, exp.rs1, exp.rs2, exp.rd, exp.rd_write, exp.illegal);
          end
        end
      end
      if (i_if_valid && o_if_ready) begin
        sbQueue.push_back(modelDecode(i_if_inst, i_if_pc));
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  // Offer one instruction until accepted (bounded), optionally jittering ex_ready
  task automatic driveInst(input logic [31:0] inst, input logic [31:0] pc, input bit jitter);
    bit done;
    done       = 1'b0;
    i_if_valid = 1'b1;
    i_if_inst  = inst;
    i_if_pc    = pc;
    for (int k = 0; k < 20 && !done; k++) begin
      if (jitter) i_ex_ready = ($urandom_range(0, 3) != 0);
      done = o_if_ready;
      tick();
    end
    i_if_valid = 1'b0;
    if (!done) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL accept_timeout: got o_if_ready=%b for 20 cycles, expected 1", o_if_ready);
    end
  endtask

  // Let everything drain and confirm nothing is left over
  task automatic drain();
    i_if_valid = 1'b0;
    i_ex_ready = 1'b1;
    repeat (4) tick();
    nCompared++;
    if (o_ex_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL drain_valid: got %b expected 0", o_ex_valid);
    end
    nCompared++;
    if (sbQueue.size() != 0) begin
      nMismatched++; $display("[TB] FAIL drain_scoreboard: got %0d pending expected 0", sbQueue.size());
    end
  endtask

  task automatic checkResetState(input string tag);
    nCompared++;
    if (o_ex_valid !== 1'b0 || o_if_ready !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL %s_handshake: got valid=%b ready=%b expected valid=0 ready=1", tag, o_ex_valid, o_if_ready);
    end
    nCompared++;
    if (o_ex_pc !== 32'h0 || o_ex_imm_value !== 32'h0 || o_ex_alu_operation !== '0) begin
      nMismatched++; $display("[TB] FAIL %s_payload: got pc=%h imm=%h op=%h expected all 0", tag, o_ex_pc, o_ex_imm_value, o_ex_alu_operation);
    end
    nCompared++;
    if (o_ex_rs1 !== 5'd0 || o_ex_rs2 !== 5'd0 || o_ex_rd !== 5'd0 || o_ex_rd_write !== 1'b0 || o_ex_illegal !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL %s_fields: got rs1=%0d rs2=%0d rd=%0d w=%b ill=%b expected all 0", tag, o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_rd_write, o_ex_illegal);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    checkResetState("reset");
  endtask

  task automatic test_decode();
    i_ex_ready = 1'b1;
    driveInst(32'hFFF00093, 32'h0000_0100, 1'b0);
    nCompared++;
    if (o_ex_valid !== 1'b1 || o_ex_alu_operation.command !== RICE_CORE_ALU_ADD ||
        o_ex_alu_operation.source_1 !== RICE_CORE_ALU_SOURCE_RS || o_ex_alu_operation.source_2 !== RICE_CORE_ALU_SOURCE_IMM) begin
      nMismatched++; $display("[TB] FAIL addi_op: got valid=%b op=%h expected valid=1 ADD RS/IMM", o_ex_valid, o_ex_alu_operation);
    end
    nCompared++;
    if (o_ex_imm_value !== 32'hFFFF_FFFF || o_ex_rs1 !== 5'd0 || o_ex_rd !== 5'd1 || o_ex_rd_write !== 1'b1 || o_ex_illegal !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL addi_fields: got imm=%h rs1=%0d rd=%0d w=%b ill=%b expected ffffffff 0 1 1 0", o_ex_imm_value, o_ex_rs1, o_ex_rd, o_ex_rd_write, o_ex_illegal);
    end
    driveInst(32'h4040D113, 32'h0000_0104, 1'b0);
    nCompared++;
    if (o_ex_alu_operation.command !== RICE_CORE_ALU_SRA || o_ex_imm_value[4:0] !== 5'd4 || o_ex_rs1 !== 5'd1 || o_ex_rd !== 5'd2 || o_ex_illegal !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL srai: got cmd=%0d sh=%0d rs1=%0d rd=%0d ill=%b expected SRA 4 1 2 0", o_ex_alu_operation.command, o_ex_imm_value[4:0], o_ex_rs1, o_ex_rd, o_ex_illegal);
    end
    driveInst(32'h0240D113, 32'h0000_0108, 1'b0);
    nCompared++;
    if (o_ex_illegal !== 1'b1 || o_ex_rd_write !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL srai_bad_funct7: got ill=%b w=%b expected ill=1 w=0", o_ex_illegal, o_ex_rd_write);
    end
    drain();
  endtask

  task automatic test_illegal();
    logic [31:0] words[2];
    words[0] = 32'h0010A093;
    words[1] = 32'h0000007F;
    i_ex_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      driveInst(words[i], 32'h0000_0200 + 32'(i * 4), 1'b0);
      nCompared++;
      if (o_ex_valid !== 1'b1 || o_ex_illegal !== 1'b1 || o_ex_rd_write !== 1'b0 || o_ex_imm_value !== 32'h0 ||
          o_ex_alu_operation.command !== RICE_CORE_ALU_ADD ||
          o_ex_alu_operation.source_1 !== RICE_CORE_ALU_SOURCE_NONE || o_ex_alu_operation.source_2 !== RICE_CORE_ALU_SOURCE_NONE) begin
        nMismatched++; $display("[TB] FAIL illegal_%0d: got valid=%b ill=%b w=%b imm=%h op=%h expected 1 1 0 0 ADD/NONE/NONE",
                                i, o_ex_valid, o_ex_illegal, o_ex_rd_write, o_ex_imm_value, o_ex_alu_operation);
      end
    end
    drain();
  endtask

  task automatic test_op_mix();
    logic [31:0] words[16];
    words = '{32'h002081B3, 32'h402081B3, 32'h0020C233, 32'h4020D2B3,
              32'h0020E333, 32'h0020F3B3, 32'h00209433, 32'h0020D4B3,
              32'h40209433, 32'hABCDE517, 32'h7FF0E593, 32'h8000C613,
              32'h01F09693, 32'h0050F013, 32'h00000001, 32'h123452B7};
    for (int i = 0; i < 16; i++) begin
      driveInst(words[i], 32'h0000_1000 + 32'(i * 4), 1'b1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_if_inst = 32'h002081B3; i_if_pc = 32'h0000_3000;
    tick();
    i_if_inst = 32'h402081B3; i_if_pc = 32'h0000_3004;
    tick();
    nCompared++;
    if (o_if_ready !== 1'b0 || o_ex_valid !== 1'b1 || o_ex_pc !== 32'h0000_3000) begin
      nMismatched++; $display("[TB] FAIL bp_full: got ready=%b valid=%b pc=%h expected 0 1 00003000", o_if_ready, o_ex_valid, o_ex_pc);
    end
    i_if_inst = 32'h0020C233; i_if_pc = 32'h0000_3008;
    repeat (2) tick();
    nCompared++;
    if (o_if_ready !== 1'b0 || o_ex_valid !== 1'b1 || o_ex_pc !== 32'h0000_3000) begin
      nMismatched++; $display("[TB] FAIL bp_hold: got ready=%b valid=%b pc=%h expected 0 1 00003000", o_if_ready, o_ex_valid, o_ex_pc);
    end
    i_ex_ready = 1'b1;
    tick();
    nCompared++;
    if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h0000_3004) begin
      nMismatched++; $display("[TB] FAIL bp_second: got valid=%b pc=%h expected 1 00003004", o_ex_valid, o_ex_pc);
    end
    tick();
    i_if_valid = 1'b0;
    nCompared++;
    if (o_ex_valid !== 1'b1 || o_ex_pc !== 32'h0000_3008) begin
      nMismatched++; $display("[TB] FAIL bp_third: got valid=%b pc=%h expected 1 00003008", o_ex_valid, o_ex_pc);
    end
    drain();
  endtask

  task automatic test_flush();
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_if_inst = 32'h0020E333; i_if_pc = 32'h0000_4000;
    tick();
    i_if_inst = 32'h0020F3B3; i_if_pc = 32'h0000_4004;
    tick();
    i_if_inst = 32'h00209433; i_if_pc = 32'h0000_4008;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_if_valid = 1'b0;
    nCompared++;
    if (o_ex_valid !== 1'b0 || o_if_ready !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL flush_state: got valid=%b ready=%b expected 0 1", o_ex_valid, o_if_ready);
    end
    i_ex_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++;
      if (o_ex_valid !== 1'b0) begin
        nMismatched++; $display("[TB] FAIL flush_ghost_%0d: got valid=%b pc=%h expected valid 0", i, o_ex_valid, o_ex_pc);
      end
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    i_ex_ready = 1'b0;
    i_if_valid = 1'b1; i_if_inst = 32'hABCDE517; i_if_pc = 32'h0000_5000;
    tick();
    i_if_inst = 32'h7FF0E593; i_if_pc = 32'h0000_5004;
    tick();
    i_if_valid = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkResetState("midreset");
    i_ex_ready = 1'b1;
    driveInst(32'h123452B7, 32'h0000_5008, 1'b0);
    nCompared++;
    if (o_ex_valid !== 1'b1 || o_ex_imm_value !== 32'h1234_5000 || o_ex_rd !== 5'd5 || o_ex_rs1 !== 5'd0 || o_ex_rd_write !== 1'b1 ||
        o_ex_alu_operation.source_1 !== RICE_CORE_ALU_SOURCE_NONE || o_ex_alu_operation.source_2 !== RICE_CORE_ALU_SOURCE_IMM) begin
      nMismatched++; $display("[TB] FAIL lui_after_reset: got valid=%b imm=%h rd=%0d rs1=%0d w=%b op=%h expected 1 12345000 5 0 1 NONE/IMM",
                              o_ex_valid, o_ex_imm_value, o_ex_rd, o_ex_rs1, o_ex_rd_write, o_ex_alu_operation);
    end
    drain();
  endtask

  // Scenario sequence and summary
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    i_clk       = 1'b0;
    i_rst       = 1'b1;
    i_flush     = 1'b0;
    i_if_valid  = 1'b0;
    i_if_pc     = 32'h0;
    i_if_inst   = 32'h0;
    i_ex_ready  = 1'b0;
    test_reset();
    test_decode();
    test_illegal();
    test_op_mix();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
